// File: rtl/cpu_pkg.sv
// Shared types and defaults for the instruction fetch path.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 12;
    localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = 16'h0000;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0] pc;
        logic                  fault;
    } fetch_rsp_t;

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Loader, fetch request and fetch response signals between the core/loader and the memory.
interface instr_fetch_mem_if
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_done;
    logic [ADDR_W:0]   ld_count;
    logic              run;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [ADDR_W-1:0] rsp_pc;
    logic              rsp_fault;
    logic              flush;

    modport master (
        output ld_en, ld_addr, ld_data, ld_done, req_valid, req_addr, rsp_ready, flush,
        input  ld_count, run, req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, ld_done, req_valid, req_addr, rsp_ready, flush,
        output ld_count, run, req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
    );

endinterface

// File: rtl/imem_ram.sv
// Single-clock RAM with one write and one read port; read returns new data on collision.
module imem_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned IDX_W  = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with boot LOAD/RUN mode, 1-cycle valid/ready fetch, flush and range faults.
module instr_fetch_mem
    import cpu_pkg::*;
#(
    parameter int unsigned       DATA_W        = DATA_W_DEF,
    parameter int unsigned       ADDR_W        = ADDR_W_DEF,
    parameter int unsigned       DEPTH         = 4096,
    parameter logic [DATA_W-1:0] NOP_WORD      = NOP_WORD_DEF,
    parameter bit                LOAD_ON_RESET = 1'b1
) (
    input logic               clk,
    input logic               reset,
    instr_fetch_mem_if.slave  bus
);

    localparam int unsigned  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam fetch_state_t RESET_STATE = LOAD_ON_RESET ? LOAD : RUN;

    fetch_state_t      r_state;
    logic              r_rsp_valid;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic              r_rsp_fault;
    logic              r_use_nop;
    logic [ADDR_W:0]   r_ld_count;

    logic              w_ld_ok;
    logic              w_req_in_range;
    logic              w_req_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_rdata;

    assign w_ld_ok        = bus.ld_en && ({1'b0, bus.ld_addr} < DEPTH_L);
    assign w_req_in_range = {1'b0, bus.req_addr} < DEPTH_L;
    assign w_req_ready    = (r_state == RUN) && !bus.flush && (!r_rsp_valid || bus.rsp_ready);
    assign w_accept       = bus.req_valid && w_req_ready;

    // Read port only fires on an in-range accept, so the RAM output register doubles as hold.
    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ld_ok),
        .i_waddr (bus.ld_addr[IDX_W-1:0]),
        .i_wdata (bus.ld_data),
        .i_re    (w_accept && w_req_in_range && !reset),
        .i_raddr (bus.req_addr[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RESET_STATE;
            r_rsp_valid <= 1'b0;
            r_rsp_pc    <= '0;
            r_rsp_fault <= 1'b0;
            r_use_nop   <= 1'b1;
            r_ld_count  <= '0;
        end else begin
            if ((r_state == LOAD) && bus.ld_done) begin
                r_state <= RUN;
            end
            if (w_ld_ok && (r_ld_count != CNT_MAX)) begin
                r_ld_count <= r_ld_count + 1'b1;
            end
            if (bus.flush) begin
                r_rsp_valid <= 1'b0;
            end else if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_pc    <= bus.req_addr;
                r_rsp_fault <= !w_req_in_range;
                r_use_nop   <= !w_req_in_range;
            end else if (r_rsp_valid && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.run       = (r_state == RUN);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_instr = r_use_nop ? NOP_WORD : w_rdata;
    assign bus.rsp_pc    = r_rsp_pc;
    assign bus.rsp_fault = r_rsp_fault;
    assign bus.ld_count  = r_ld_count;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: directed scenarios followed by random traffic.
module tb_instr_fetch_mem;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] NOP   = 16'hE000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_mem_if #(.DATA_W(16), .ADDR_W(12)) bus();

    instr_fetch_mem #(
        .DATA_W        (16),
        .ADDR_W        (12),
        .DEPTH         (DEPTH),
        .NOP_WORD      (NOP),
        .LOAD_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [15:0]  m_mem [DEPTH];
    bit           m_run;
    bit           m_valid;
    int unsigned  m_cnt;
    fetch_rsp_t   q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a response is consumed when valid && ready and not flushed or reset.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.rsp_valid && bus.rsp_ready && !bus.flush) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got pc %h, expected no response", bus.rsp_pc);
            end else begin
                fetch_rsp_t e;
                e = q.pop_front();
                chk("rsp_instr", 32'(bus.rsp_instr), 32'(e.instr));
                chk("rsp_pc", 32'(bus.rsp_pc), 32'(e.pc));
                chk("rsp_fault", 32'(bus.rsp_fault), 32'(e.fault));
            end
        end
    end

    task automatic drv(input logic rv, input logic [11:0] ra, input logic rr, input logic fl,
                       input logic le, input logic [11:0] la, input logic [15:0] ld,
                       input logic dn);
        bus.req_valid = rv;
        bus.req_addr  = ra;
        bus.rsp_ready = rr;
        bus.flush     = fl;
        bus.ld_en     = le;
        bus.ld_addr   = la;
        bus.ld_data   = ld;
        bus.ld_done   = dn;
    endtask

    // One clock: check visible state against the model, then advance the model over the edge.
    task automatic step();
        logic exp_ready;
        logic acc;
        fetch_rsp_t e;
        @(negedge clk);
        exp_ready = m_run && !bus.flush && (!m_valid || bus.rsp_ready);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
        chk("run", 32'(bus.run), 32'(m_run));
        chk("ld_count", 32'(bus.ld_count), m_cnt);
        if (reset) begin
            m_run   = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
            q.delete();
        end else begin
            if (bus.ld_en && bus.ld_addr < DEPTH) begin
                m_mem[int'(bus.ld_addr)] = bus.ld_data;
                if (m_cnt < 4096) m_cnt++;
            end
            acc = bus.req_valid && exp_ready;
            if (bus.flush) begin
                if (m_valid) void'(q.pop_front());
                m_valid = 1'b0;
            end else if (acc) begin
                e.pc    = bus.req_addr;
                e.fault = (bus.req_addr >= DEPTH);
                e.instr = e.fault ? NOP : m_mem[int'(bus.req_addr)];
                q.push_back(e);
                m_valid = 1'b1;
            end else if (m_valid && bus.rsp_ready) begin
                m_valid = 1'b0;
            end
            if (!m_run && bus.ld_done) m_run = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_run   = 1'b0;
        m_valid = 1'b0;
        m_cnt   = 0;
        chk("reset_run", 32'(bus.run), 0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset_rsp_instr", 32'(bus.rsp_instr), 32'(NOP));
        chk("reset_rsp_pc", 32'(bus.rsp_pc), 0);
        chk("reset_rsp_fault", 32'(bus.rsp_fault), 0);
        chk("reset_ld_count", 32'(bus.ld_count), 0);

        // Load while a request waits; ld_done cycle itself must not accept.
        drv(1, 0, 1, 0, 1, 0, 16'h0011, 0); step();
        drv(1, 0, 1, 0, 1, 1, 16'h6021, 0); step();
        drv(1, 0, 1, 0, 1, 2, 16'h6032, 0); step();
        drv(1, 0, 1, 0, 0, 0, 16'h0000, 1); step();
        drv(1, 0, 1, 0, 0, 0, 16'h0000, 0); step();
        drv(1, 1, 1, 0, 0, 0, 16'h0000, 0); step();
        drv(1, 2, 1, 0, 0, 0, 16'h0000, 0); step();
        drv(0, 0, 1, 0, 0, 0, 16'h0000, 0); step();
        chk("ld_count_3", 32'(bus.ld_count), 3);

        // Backpressure with PC 1 held.
        drv(1, 0, 1, 0, 0, 0, 16'h0000, 0); step();
        drv(1, 1, 1, 0, 0, 0, 16'h0000, 0); step();
        for (int i = 0; i < 3; i++) begin
            drv(1, 2, 0, 0, 0, 0, 16'h0000, 0); step();
            chk("stall_pc", 32'(bus.rsp_pc), 1);
            chk("stall_instr", 32'(bus.rsp_instr), 32'h6021);
        end
        drv(1, 2, 1, 0, 0, 0, 16'h0000, 0); step();
        drv(0, 0, 1, 0, 0, 0, 16'h0000, 0); step();

        // Out-of-range fetch and dropped out-of-range write.
        drv(1, 9, 1, 0, 0, 0, 16'h0000, 0); step();
        chk("fault_flag", 32'(bus.rsp_fault), 1);
        chk("fault_instr", 32'(bus.rsp_instr), 32'(NOP));
        drv(0, 0, 1, 0, 1, 9, 16'h1234, 0); step();
        chk("drop_ld_count", 32'(bus.ld_count), 3);

        // Flush a stalled response with a request pending.
        drv(1, 1, 0, 0, 0, 0, 16'h0000, 0); step();
        drv(1, 2, 0, 0, 0, 0, 16'h0000, 0); step();
        drv(1, 2, 0, 1, 0, 0, 16'h0000, 0); step();
        chk("flush_valid", 32'(bus.rsp_valid), 0);
        drv(1, 0, 1, 0, 0, 0, 16'h0000, 0); step();
        drv(0, 0, 1, 0, 0, 0, 16'h0000, 0); step();

        // Same-cycle write and fetch of address 3.
        drv(1, 3, 1, 0, 1, 3, 16'hABCD, 0); step();
        chk("collision_instr", 32'(bus.rsp_instr), 32'hABCD);
        drv(0, 0, 1, 0, 0, 0, 16'h0000, 0); step();

        // Reset in the middle of a stall; memory must survive.
        drv(1, 0, 0, 0, 0, 0, 16'h0000, 0); step();
        drv(0, 0, 0, 0, 0, 0, 16'h0000, 0); step();
        reset = 1'b1; step();
        reset = 1'b0;
        chk("rst2_run", 32'(bus.run), 0);
        chk("rst2_valid", 32'(bus.rsp_valid), 0);
        chk("rst2_ld_count", 32'(bus.ld_count), 0);
        drv(0, 0, 1, 0, 0, 0, 16'h0000, 1); step();
        drv(1, 3, 1, 0, 0, 0, 16'h0000, 0); step();
        chk("retained_instr", 32'(bus.rsp_instr), 32'hABCD);
        drv(0, 0, 1, 0, 0, 0, 16'h0000, 0); step();

        for (int a = 0; a < int'(DEPTH); a++) begin
            drv(0, 0, 1, 0, 1, 12'(a), 16'($urandom), 0); step();
        end

        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drv(1'($urandom_range(0, 1)), 12'($urandom_range(0, 11)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                !reset && ($urandom_range(0, 4) == 0), 12'($urandom_range(0, 11)),
                16'($urandom), ($urandom_range(0, 9) == 0));
            step();
        end
        reset = 1'b0;
        drv(0, 0, 1, 0, 0, 0, 16'h0000, 1); step();
        drv(0, 0, 1, 0, 0, 0, 16'h0000, 0); step();
        step();
        chk("queue_drained", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
